// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, reads the zero-latency ROM, registers {instr, pc+1, valid} into IF/ID (1 clk).
// Stall holds the PC and IF/ID, a branch redirect flushes IF/ID. The optional perf counters are enabled by IF_PERF_CNT_EN.
module instruction_fetch_stage #(
  parameter int                   PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [15:0]          NOP_INSTR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_pc,
  input  logic [15:0]         imem_instruction,
  output logic [15:0]         if_id_instruction,
  output logic [PC_WIDTH-1:0] if_id_pc_plus1,
  output logic                if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_count,
  output logic [31:0]         perf_bubble_count
`endif
);

  typedef struct packed {
    logic [15:0]         instr;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic                vld;
  } if_id_t;

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc_plus1: '0, vld: 1'b0};

  logic [PC_WIDTH-1:0] r_pc;
  if_id_t              r_if_id;
  logic [PC_WIDTH-1:0] w_pc_plus1;

  // Natural modulo-2^PC_WIDTH wrap: all-ones advances to zero.
  assign w_pc_plus1 = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_if_id <= BUBBLE;
    end else if (branch_taken) begin
      r_pc    <= branch_target;
      r_if_id <= BUBBLE;
    end else if (!stall) begin
      r_pc    <= w_pc_plus1;
      r_if_id <= '{instr: imem_instruction, pc_plus1: w_pc_plus1, vld: 1'b1};
    end
  end

  assign imem_pc           = r_pc;
  assign if_id_instruction = r_if_id.instr;
  assign if_id_pc_plus1    = r_if_id.pc_plus1;
  assign if_id_valid       = r_if_id.vld;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (branch_taken) begin
      if (r_bubble_cnt != 32'hFFFF_FFFF) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else if (!stall) begin
      if (r_fetch_cnt != 32'hFFFF_FFFF) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign perf_fetch_count  = r_fetch_cnt;
  assign perf_bubble_count = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, async reset check, then random stall/branch traffic vs a model.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_pc;
  logic [15:0] imem_instruction;
  logic [15:0] if_id_instruction;
  logic [7:0]  if_id_pc_plus1;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_bubble_count;
`endif

  logic [15:0] rom [256];
  assign imem_instruction = rom[imem_pc];

  instruction_fetch_stage #(.PC_WIDTH(8), .RESET_PC(8'h00), .NOP_INSTR(16'h0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_pc           (imem_pc),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus1    (if_id_pc_plus1),
    .if_id_valid       (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_count  (perf_fetch_count),
    .perf_bubble_count (perf_bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rom_val(input int a);
    logic [15:0] v;
    case (a)
      0: v = 16'h9208;
      1: v = 16'h9448;
      2: v = 16'h9688;
      3: v = 16'h1898;
      default: v = 16'h5000 | 16'(a);
    endcase
    return v;
  endfunction

  typedef struct {
    logic        stl;
    logic        br;
    logic [7:0]  tgt;
    logic [7:0]  pc;
    logic [15:0] ins;
    logic [7:0]  pp1;
    logic        vld;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [7:0] t,
                              input logic [7:0] p, input logic [15:0] i,
                              input logic [7:0] pp, input logic v);
    vec_t r;
    r.stl = s; r.br = b; r.tgt = t; r.pc = p; r.ins = i; r.pp1 = pp; r.vld = v;
    return r;
  endfunction

  vec_t tbl[$];

  // Model state for the randomized phase: architectural PC and the IF/ID triple.
  int          m_pc;
  logic [15:0] m_ins;
  int          m_pp1;
  logic        m_vld;
  int          m_fetch;
  int          m_bub;

  task automatic model_reset();
    m_pc = 0; m_ins = 16'h0000; m_pp1 = 0; m_vld = 1'b0; m_fetch = 0; m_bub = 0;
  endtask

  task automatic model_edge(input logic s, input logic b, input int t);
    if (b) begin
      m_pc = t; m_ins = 16'h0000; m_pp1 = 0; m_vld = 1'b0; m_bub++;
    end else if (!s) begin
      m_ins = rom[m_pc];
      m_pp1 = (m_pc + 1) % 256;
      m_vld = 1'b1;
      m_pc  = (m_pc + 1) % 256;
      m_fetch++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"},    32'(imem_pc),           32'(m_pc));
    check({tag, "_instr"}, 32'(if_id_instruction), 32'(m_ins));
    check({tag, "_pp1"},   32'(if_id_pc_plus1),    32'(m_pp1));
    check({tag, "_vld"},   32'(if_id_valid),       32'(m_vld));
`ifdef IF_PERF_CNT_EN
    check({tag, "_pfetch"}, perf_fetch_count,  32'(m_fetch));
    check({tag, "_pbub"},   perf_bubble_count, 32'(m_bub));
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = rom_val(i);

    // Directed walk: free-run, 3-cycle stall at PC=2, branch at PC=7,
    // stall+branch collision, back-to-back branches, and the 8'hFF wrap.
    tbl.push_back(mk(0, 0, 8'h00, 8'h01, 16'h9208, 8'h01, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h02, 16'h9448, 8'h02, 1));
    tbl.push_back(mk(1, 0, 8'h00, 8'h02, 16'h9448, 8'h02, 1));
    tbl.push_back(mk(1, 0, 8'h00, 8'h02, 16'h9448, 8'h02, 1));
    tbl.push_back(mk(1, 0, 8'h00, 8'h02, 16'h9448, 8'h02, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h03, 16'h9688, 8'h03, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h04, 16'h1898, 8'h04, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h05, 16'h5004, 8'h05, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h06, 16'h5005, 8'h06, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h07, 16'h5006, 8'h07, 1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h01, 16'h9208, 8'h01, 1));
    tbl.push_back(mk(1, 1, 8'h05, 8'h05, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h06, 16'h5005, 8'h06, 1));
    tbl.push_back(mk(0, 1, 8'h20, 8'h20, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h30, 8'h30, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h31, 16'h5030, 8'h31, 1));
    tbl.push_back(mk(0, 1, 8'hFF, 8'hFF, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 16'h50FF, 8'h00, 1));

    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    32'(imem_pc),           32'h0);
    check("rst_instr", 32'(if_id_instruction), 32'h0);
    check("rst_pp1",   32'(if_id_pc_plus1),    32'h0);
    check("rst_vld",   32'(if_id_valid),       32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_vld", 32'(if_id_valid), 32'h0);

    begin
      int exp_fetch = 0;
      int exp_bub   = 0;
      for (int k = 0; k < tbl.size(); k++) begin
        stall = tbl[k].stl; branch_taken = tbl[k].br; branch_target = tbl[k].tgt;
        @(posedge clk);
        #1;
        if (tbl[k].br) exp_bub++;
        else if (!tbl[k].stl) exp_fetch++;
        check($sformatf("v%0d_pc", k),    32'(imem_pc),           32'(tbl[k].pc));
        check($sformatf("v%0d_instr", k), 32'(if_id_instruction), 32'(tbl[k].ins));
        check($sformatf("v%0d_pp1", k),   32'(if_id_pc_plus1),    32'(tbl[k].pp1));
        check($sformatf("v%0d_vld", k),   32'(if_id_valid),       32'(tbl[k].vld));
`ifdef IF_PERF_CNT_EN
        check($sformatf("v%0d_pfetch", k), perf_fetch_count,  32'(exp_fetch));
        check($sformatf("v%0d_pbub", k),   perf_bubble_count, 32'(exp_bub));
`endif
      end
    end

    // Async reset in the middle of a stall, no clock edge in between.
    stall = 1'b1; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    check("stall_hold_vld", 32'(if_id_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc",    32'(imem_pc),           32'h0);
    check("arst_instr", 32'(if_id_instruction), 32'h0);
    check("arst_pp1",   32'(if_id_pc_plus1),    32'h0);
    check("arst_vld",   32'(if_id_valid),       32'h0);
`ifdef IF_PERF_CNT_EN
    check("arst_pfetch", perf_fetch_count,  32'h0);
    check("arst_pbub",   perf_bubble_count, 32'h0);
`endif
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);

    for (int c = 0; c < 3000; c++) begin
      logic s;
      logic b;
      int   t;
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 12);
      t = $urandom_range(0, 255);
      if ($urandom_range(0, 99) < 3) t = 255;
      stall = s; branch_taken = b; branch_target = 8'(t);
      @(posedge clk);
      #1;
      model_edge(s, b, t);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the mips_16 five-stage pipeline.
- Owns the program counter and drives the address into the asynchronous instruction ROM.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls and EX-stage branch redirects, including flushing the wrong-path fetch.

Parameters:
- PC_WIDTH, 8: width of the program counter and of all PC-valued ports; word-addressed.
- RESET_PC, 0: PC value loaded while reset is asserted.
- NOP_INSTR, 16'h0000: encoding inserted into IF/ID on a flush or bubble.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall request; holds PC and IF/ID.
- branch_taken  input  1  EX-stage redirect request, single-cycle pulse.
- branch_target  input  PC_WIDTH  redirect address, valid when branch_taken=1.
- imem_pc  output  PC_WIDTH  address to the instruction ROM; equals the current PC register.
- imem_instruction  input  16  combinational ROM data for imem_pc, same cycle.
- if_id_instruction  output  16  registered instruction to ID.
- if_id_pc_plus1  output  PC_WIDTH  registered (fetch PC + 1) for ID/EX branch arithmetic.
- if_id_valid  output  1  1 = if_id_instruction is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - PC=RESET_PC; if_id_instruction=NOP_INSTR; if_id_pc_plus1=0; if_id_valid=0.
  - Reset mid-operation discards any pending redirect or stall immediately.
- imem_pc is combinational from the PC register. The ROM read is zero-latency, so the instruction at PC is sampled at the same edge that advances PC.
- Per-edge update, in priority order:
  1. branch_taken=1:
     - PC <= branch_target.
     - IF/ID <= {NOP_INSTR, pc_plus1 = 0, valid = 0}; the wrong-path fetch is flushed.
     - Wins over stall when both are asserted.
  2. stall=1, branch_taken=0:
     - PC and all IF/ID outputs hold.
     - Instruction bits held in IF/ID are not re-sampled from imem_instruction.
  3. Otherwise (normal advance):
     - PC <= PC + 1.
     - IF/ID <= {imem_instruction, PC + 1, valid = 1}.
- Arithmetic:
  - PC + 1 is modulo 2^PC_WIDTH; PC = all-ones wraps to 0 with no flag.
  - if_id_pc_plus1 is truncated to PC_WIDTH.
- Latency:
  - Instruction at address A is visible on if_id_instruction one clk after PC=A with no stall.
  - Branch penalty is exactly one bubble (if_id_valid=0 for one cycle), then the target instruction arrives on the next cycle.
- Back-to-back branch_taken pulses: each pulse redirects; IF/ID stays a bubble for every cycle a pulse is present.
- Stall lasting N cycles: PC frozen for N edges; the fetch resumes at the same PC, with no duplicate or lost instruction.
- No internal FSM beyond the PC/valid registers. The stage is always fetching when not stalled.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_count[31:0] and perf_bubble_count[31:0].
  - perf_fetch_count increments on every normal-advance edge.
  - perf_bubble_count increments on every branch_taken flush edge.
  - Stall edges increment neither counter.
  - Both counters reset to 0 on rst=0 and saturate at 32'hFFFFFFFF.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run with ROM[0..3] = 16'h9208, 16'h9448, 16'h9688, 16'h1898:
  - if_id_valid=0 in the first cycle after reset release.
  - Then if_id_instruction = 9208, 9448, 9688, 1898 on consecutive cycles, with if_id_pc_plus1 = 1, 2, 3, 4.
- Stall held 3 cycles while PC=2:
  - imem_pc stays 2 and IF/ID holds {9448, 2, 1} for 3 cycles.
  - After release the next IF/ID value is {9688, 3, 1}.
- branch_taken=1 with branch_target=0 while PC=7:
  - Next cycle PC=0 and IF/ID = {0000, 0, 0}.
  - The following cycle IF/ID = {ROM[0], 1, 1}.
- stall=1 and branch_taken=1 with branch_target=5 in the same cycle:
  - Redirect wins; PC=5 and valid=0.
  - Stall is ignored for that edge.
- PC_WIDTH=8 with PC=8'hFF and no stall:
  - Next PC=8'h00 and if_id_pc_plus1=8'h00.
- Assert rst=0 asynchronously mid-cycle during a stall:
  - Outputs go to their reset values immediately, without waiting for clk.
  - With IF_PERF_CNT_EN defined, both counters read 0.
